ex_sequencer: RTL and testbench

Initiator side of the executor's compute/finished handshake. It accepts one operation at a time from the operand stage over a valid/ready channel and registers the operands into the executor inputs. For multi-cycle (MDU) operations it holds `compute` until `finished` returns, then captures the result into a response register drained over a second valid/ready channel. It also owns the executor stall and flush lines, including a watchdog abort for MDU operations that never finish.

---
 rtl/ex_sequencer_if.sv | 56 +++++
 rtl/ex_sequencer.sv | 133 +++++++++++++
 tb/tb_ex_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_sequencer_if.sv
// Request, executor and response channels between the operand stage, the
// executor and the writeback side of the ex_sequencer.
interface ex_sequencer_if #(
    parameter int FUNC_W = 4
);
    logic              s_hold_i;
    logic              s_flush_i;

    logic              s_req_valid_i;
    logic              s_req_ready_o;
    logic              s_req_mdu_i;
    logic [FUNC_W-1:0] s_req_function_i;
    logic [31:0]       s_req_op1_i;
    logic [31:0]       s_req_op2_i;
    logic [4:0]        s_req_tag_i;

    logic              s_ex_compute_o;
    logic [FUNC_W-1:0] s_ex_function_o;
    logic [31:0]       s_ex_op1_o;
    logic [31:0]       s_ex_op2_o;
    logic              s_ex_stall_o;
    logic              s_ex_flush_o;
    logic              s_ex_finished_i;
    logic [31:0]       s_ex_result_i;

    logic              s_rsp_valid_o;
    logic              s_rsp_ready_i;
    logic [31:0]       s_rsp_result_o;
    logic [4:0]        s_rsp_tag_o;

    logic              s_timeout_o;

    // Sequencer side.
    modport master (
        input  s_hold_i, s_flush_i,
        input  s_req_valid_i, s_req_mdu_i, s_req_function_i,
        input  s_req_op1_i, s_req_op2_i, s_req_tag_i,
        input  s_ex_finished_i, s_ex_result_i, s_rsp_ready_i,
        output s_req_ready_o,
        output s_ex_compute_o, s_ex_function_o, s_ex_op1_o, s_ex_op2_o,
        output s_ex_stall_o, s_ex_flush_o,
        output s_rsp_valid_o, s_rsp_result_o, s_rsp_tag_o, s_timeout_o
    );

    // Environment side: operand stage, executor and response consumer.
    modport slave (
        output s_hold_i, s_flush_i,
        output s_req_valid_i, s_req_mdu_i, s_req_function_i,
        output s_req_op1_i, s_req_op2_i, s_req_tag_i,
        output s_ex_finished_i, s_ex_result_i, s_rsp_ready_i,
        input  s_req_ready_o,
        input  s_ex_compute_o, s_ex_function_o, s_ex_op1_o, s_ex_op2_o,
        input  s_ex_stall_o, s_ex_flush_o,
        input  s_rsp_valid_o, s_rsp_result_o, s_rsp_tag_o, s_timeout_o
    );
endinterface

// File: rtl/ex_sequencer.sv
// Initiator of the executor compute/finished handshake: registers one op at a
// time, waits for ALU/MDU completion and buffers the result for writeback.
module ex_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int FUNC_W  = 4
) (
    input  logic              s_clk_i,
    input  logic              s_reset_i,
    ex_sequencer_if.master    bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic [FUNC_W-1:0] func_reg;
    logic [31:0]       op1_reg;
    logic [31:0]       op2_reg;
    logic [4:0]        tag_reg;
    logic              mdu_reg;

    logic              rsp_valid_reg, rsp_valid_next;
    logic [31:0]       rsp_result_reg;
    logic [4:0]        rsp_tag_reg;
    logic              timeout_reg;

    logic              req_ready;
    logic              load;
    logic              capture;
    logic              abort;
    logic              ex_flush;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;

        req_ready = !s_reset_i && !bus.s_hold_i && !bus.s_flush_i &&
                    (state_reg == IDLE) &&
                    (!rsp_valid_reg || bus.s_rsp_ready_i);

        if (state_reg == IDLE) begin
            if (req_ready && bus.s_req_valid_i) begin
                state_next = EXEC;
                cnt_next   = '0;
                load       = 1'b1;
            end
        end else if (!bus.s_hold_i) begin
            // A frozen executor neither completes nor ages the watchdog.
            if (!mdu_reg || bus.s_ex_finished_i) begin
                capture    = 1'b1;
                state_next = IDLE;
            end else if (cnt_reg == CNT_LIMIT) begin
                abort      = 1'b1;
                state_next = IDLE;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end

        ex_flush = bus.s_flush_i || abort;

        if (bus.s_flush_i) begin
            state_next = IDLE;
            capture    = 1'b0;
        end

        // Flush beats capture and drain; capture only lands on an empty register.
        if (ex_flush) begin
            rsp_valid_next = 1'b0;
        end else if (capture) begin
            rsp_valid_next = 1'b1;
        end else if (rsp_valid_reg && bus.s_rsp_ready_i) begin
            rsp_valid_next = 1'b0;
        end else begin
            rsp_valid_next = rsp_valid_reg;
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            func_reg       <= '0;
            op1_reg        <= '0;
            op2_reg        <= '0;
            tag_reg        <= '0;
            mdu_reg        <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_tag_reg    <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rsp_valid_reg <= rsp_valid_next;
            if (load) begin
                func_reg <= bus.s_req_function_i;
                op1_reg  <= bus.s_req_op1_i;
                op2_reg  <= bus.s_req_op2_i;
                tag_reg  <= bus.s_req_tag_i;
                mdu_reg  <= bus.s_req_mdu_i;
            end
            if (capture) begin
                rsp_result_reg <= bus.s_ex_result_i;
                rsp_tag_reg    <= tag_reg;
            end
            if (abort) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign bus.s_req_ready_o   = req_ready;
    assign bus.s_ex_compute_o  = (state_reg == EXEC) && mdu_reg;
    assign bus.s_ex_function_o = func_reg;
    assign bus.s_ex_op1_o      = op1_reg;
    assign bus.s_ex_op2_o      = op2_reg;
    assign bus.s_ex_stall_o    = bus.s_hold_i;
    assign bus.s_ex_flush_o    = ex_flush;
    assign bus.s_rsp_valid_o   = rsp_valid_reg;
    assign bus.s_rsp_result_o  = rsp_result_reg;
    assign bus.s_rsp_tag_o     = rsp_tag_reg;
    assign bus.s_timeout_o     = timeout_reg;
endmodule

// File: tb/tb_ex_sequencer.sv
// Directed bench for ex_sequencer: ALU/MDU latency, backpressure, flush,
// watchdog abort, hold and reset behaviour with hand-computed expectations.
module tb_ex_sequencer;
    localparam int TIMEOUT = 8;
    localparam int FUNC_W  = 4;

    logic s_clk_i   = 1'b0;
    logic s_reset_i = 1'b1;
    always #5 s_clk_i = ~s_clk_i;

    ex_sequencer_if #(.FUNC_W(FUNC_W)) bus ();

    ex_sequencer #(
        .TIMEOUT(TIMEOUT),
        .FUNC_W (FUNC_W)
    ) dut (
        .s_clk_i  (s_clk_i),
        .s_reset_i(s_reset_i),
        .bus      (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_compute;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next edge and return single-cycle strobes to idle.
    task automatic step();
        @(posedge s_clk_i);
        #1;
        bus.s_req_valid_i   = 1'b0;
        bus.s_ex_finished_i = 1'b0;
        bus.s_flush_i       = 1'b0;
        bus.s_hold_i        = 1'b0;
    endtask

    task automatic settle();
        @(negedge s_clk_i);
    endtask

    task automatic drive_req(input logic mdu, input logic [FUNC_W-1:0] fn,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] tag);
        bus.s_req_valid_i    = 1'b1;
        bus.s_req_mdu_i      = mdu;
        bus.s_req_function_i = fn;
        bus.s_req_op1_i      = a;
        bus.s_req_op2_i      = b;
        bus.s_req_tag_i      = tag;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        bus.s_hold_i         = 1'b0;
        bus.s_flush_i        = 1'b0;
        bus.s_req_valid_i    = 1'b0;
        bus.s_req_mdu_i      = 1'b0;
        bus.s_req_function_i = '0;
        bus.s_req_op1_i      = '0;
        bus.s_req_op2_i      = '0;
        bus.s_req_tag_i      = '0;
        bus.s_ex_finished_i  = 1'b0;
        bus.s_ex_result_i    = '0;
        bus.s_rsp_ready_i    = 1'b1;

        // Reset state
        step(); step(); settle();
        check("rst_ready",   32'(bus.s_req_ready_o), 32'd0);
        check("rst_compute", 32'(bus.s_ex_compute_o), 32'd0);
        check("rst_rsp_valid", 32'(bus.s_rsp_valid_o), 32'd0);
        check("rst_rsp_result", bus.s_rsp_result_o, 32'd0);
        check("rst_rsp_tag", 32'(bus.s_rsp_tag_o), 32'd0);
        check("rst_timeout", 32'(bus.s_timeout_o), 32'd0);
        check("rst_op1",     bus.s_ex_op1_o, 32'd0);
        check("rst_func",    32'(bus.s_ex_function_o), 32'd0);
        step(); s_reset_i = 1'b0; settle();
        check("ready_after_reset", 32'(bus.s_req_ready_o), 32'd1);

        // ALU add 5+7, tag 3
        step(); drive_req(1'b0, 4'h1, 32'd5, 32'd7, 5'd3); settle();
        check("alu_accept", 32'(bus.s_req_ready_o), 32'd1);
        step(); bus.s_ex_result_i = 32'd12; settle();
        check("alu_op1",     bus.s_ex_op1_o, 32'd5);
        check("alu_op2",     bus.s_ex_op2_o, 32'd7);
        check("alu_func",    32'(bus.s_ex_function_o), 32'd1);
        check("alu_compute", 32'(bus.s_ex_compute_o), 32'd0);
        check("alu_busy_ready", 32'(bus.s_req_ready_o), 32'd0);
        check("alu_rsp_early", 32'(bus.s_rsp_valid_o), 32'd0);
        step(); settle();
        check("alu_rsp_valid", 32'(bus.s_rsp_valid_o), 32'd1);
        check("alu_rsp_result", bus.s_rsp_result_o, 32'd12);
        check("alu_rsp_tag", 32'(bus.s_rsp_tag_o), 32'd3);
        check("alu_ready_again", 32'(bus.s_req_ready_o), 32'd1);
        $display("txn alu tag=%0d result=%h", bus.s_rsp_tag_o, bus.s_rsp_result_o);
        step(); settle();
        check("alu_rsp_drained", 32'(bus.s_rsp_valid_o), 32'd0);

        // MDU op, finished on the 7th EXEC cycle
        step(); drive_req(1'b1, 4'h2, 32'd100, 32'd3, 5'd7); settle();
        check("mdu_accept", 32'(bus.s_req_ready_o), 32'd1);
        n_compute = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 6) begin
                bus.s_ex_finished_i = 1'b1;
                bus.s_ex_result_i   = 32'hDEADBEEF;
            end
            settle();
            if (bus.s_ex_compute_o) n_compute++;
            check("mdu_no_rsp_yet", 32'(bus.s_rsp_valid_o), 32'd0);
        end
        check("mdu_compute_cycles", 32'(n_compute), 32'd7);

        // Response backpressure with a new request waiting
        step(); bus.s_rsp_ready_i = 1'b0; drive_req(1'b1, 4'h3, 32'd0, 32'd0, 5'd9); settle();
        check("mdu_compute_drop", 32'(bus.s_ex_compute_o), 32'd0);
        check("mdu_rsp_valid", 32'(bus.s_rsp_valid_o), 32'd1);
        check("mdu_rsp_result", bus.s_rsp_result_o, 32'hDEADBEEF);
        check("mdu_rsp_tag", 32'(bus.s_rsp_tag_o), 32'd7);
        check("bp_ready", 32'(bus.s_req_ready_o), 32'd0);
        $display("txn mdu tag=%0d result=%h", bus.s_rsp_tag_o, bus.s_rsp_result_o);
        for (int i = 0; i < 3; i++) begin
            step(); drive_req(1'b1, 4'h3, 32'd0, 32'd0, 5'd9); settle();
            check("bp_rsp_valid", 32'(bus.s_rsp_valid_o), 32'd1);
            check("bp_rsp_result", bus.s_rsp_result_o, 32'hDEADBEEF);
            check("bp_ready", 32'(bus.s_req_ready_o), 32'd0);
        end
        step(); bus.s_rsp_ready_i = 1'b1; drive_req(1'b1, 4'h3, 32'd0, 32'd0, 5'd9); settle();
        check("bp_release_ready", 32'(bus.s_req_ready_o), 32'd1);

        // Flush on the 3rd EXEC cycle of that op
        step(); settle();
        check("fl_compute", 32'(bus.s_ex_compute_o), 32'd1);
        check("fl_rsp_drained", 32'(bus.s_rsp_valid_o), 32'd0);
        step(); settle();
        step(); bus.s_flush_i = 1'b1; settle();
        check("fl_ex_flush", 32'(bus.s_ex_flush_o), 32'd1);
        check("fl_ready", 32'(bus.s_req_ready_o), 32'd0);
        step(); settle();
        check("fl_compute_drop", 32'(bus.s_ex_compute_o), 32'd0);
        check("fl_no_rsp", 32'(bus.s_rsp_valid_o), 32'd0);
        check("fl_ex_flush_end", 32'(bus.s_ex_flush_o), 32'd0);
        check("fl_idle_ready", 32'(bus.s_req_ready_o), 32'd1);
        $display("txn flush tag=9 dropped");

        // Watchdog: MDU op that never finishes
        step(); drive_req(1'b1, 4'h4, 32'd1, 32'd1, 5'd2); settle();
        check("wd_accept", 32'(bus.s_req_ready_o), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(); settle();
            check("wd_ex_flush", 32'(bus.s_ex_flush_o), (i == 7) ? 32'd1 : 32'd0);
        end
        check("wd_timeout_pre", 32'(bus.s_timeout_o), 32'd0);
        step(); settle();
        check("wd_compute_drop", 32'(bus.s_ex_compute_o), 32'd0);
        check("wd_no_rsp", 32'(bus.s_rsp_valid_o), 32'd0);
        check("wd_timeout", 32'(bus.s_timeout_o), 32'd1);
        check("wd_idle_ready", 32'(bus.s_req_ready_o), 32'd1);
        $display("txn watchdog tag=2 aborted timeout=%0d", bus.s_timeout_o);

        // Finished on the watchdog limit cycle wins
        step(); drive_req(1'b1, 4'h5, 32'd2, 32'd2, 5'd6); settle();
        check("lim_accept", 32'(bus.s_req_ready_o), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 7) begin
                bus.s_ex_finished_i = 1'b1;
                bus.s_ex_result_i   = 32'h00001234;
            end
            settle();
        end
        check("lim_no_abort", 32'(bus.s_ex_flush_o), 32'd0);
        step(); settle();
        check("lim_rsp_valid", 32'(bus.s_rsp_valid_o), 32'd1);
        check("lim_rsp_result", bus.s_rsp_result_o, 32'h00001234);
        check("lim_rsp_tag", 32'(bus.s_rsp_tag_o), 32'd6);
        check("timeout_sticky", 32'(bus.s_timeout_o), 32'd1);
        $display("txn limit tag=%0d result=%h", bus.s_rsp_tag_o, bus.s_rsp_result_o);

        // Hold for 3 cycles while finished is high
        step(); drive_req(1'b1, 4'h6, 32'd3, 32'd3, 5'd4); settle();
        check("hold_accept", 32'(bus.s_req_ready_o), 32'd1);
        step(); settle();
        check("hold_compute", 32'(bus.s_ex_compute_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            bus.s_hold_i        = 1'b1;
            bus.s_ex_finished_i = 1'b1;
            bus.s_ex_result_i   = 32'hCAFE0004;
            settle();
            check("hold_stall", 32'(bus.s_ex_stall_o), 32'd1);
            check("hold_ready", 32'(bus.s_req_ready_o), 32'd0);
            check("hold_compute_kept", 32'(bus.s_ex_compute_o), 32'd1);
            check("hold_no_capture", 32'(bus.s_rsp_valid_o), 32'd0);
        end
        step(); bus.s_ex_finished_i = 1'b1; settle();
        check("hold_release_stall", 32'(bus.s_ex_stall_o), 32'd0);
        check("hold_release_no_rsp", 32'(bus.s_rsp_valid_o), 32'd0);
        step(); settle();
        check("hold_rsp_valid", 32'(bus.s_rsp_valid_o), 32'd1);
        check("hold_rsp_result", bus.s_rsp_result_o, 32'hCAFE0004);
        check("hold_rsp_tag", 32'(bus.s_rsp_tag_o), 32'd4);
        check("hold_compute_drop", 32'(bus.s_ex_compute_o), 32'd0);
        $display("txn hold tag=%0d result=%h", bus.s_rsp_tag_o, bus.s_rsp_result_o);

        // Flush in the same cycle as a request
        step(); drive_req(1'b1, 4'h7, 32'd8, 32'd8, 5'd5); bus.s_flush_i = 1'b1; settle();
        check("flacc_ready", 32'(bus.s_req_ready_o), 32'd0);
        check("flacc_ex_flush", 32'(bus.s_ex_flush_o), 32'd1);
        step(); settle();
        check("flacc_not_accepted", 32'(bus.s_ex_compute_o), 32'd0);
        check("flacc_idle_ready", 32'(bus.s_req_ready_o), 32'd1);
        $display("txn flush_accept tag=5 suppressed");

        // Reset in the middle of an MDU op
        step(); drive_req(1'b1, 4'h8, 32'd9, 32'd9, 5'd1); settle();
        check("rmid_accept", 32'(bus.s_req_ready_o), 32'd1);
        step(); settle();
        check("rmid_compute", 32'(bus.s_ex_compute_o), 32'd1);
        step(); s_reset_i = 1'b1; settle();
        check("rmid_ready", 32'(bus.s_req_ready_o), 32'd0);
        step(); s_reset_i = 1'b0; settle();
        check("rmid_compute_drop", 32'(bus.s_ex_compute_o), 32'd0);
        check("rmid_no_rsp", 32'(bus.s_rsp_valid_o), 32'd0);
        check("rmid_timeout_clear", 32'(bus.s_timeout_o), 32'd0);
        check("rmid_op1_clear", bus.s_ex_op1_o, 32'd0);
        check("rmid_ready_after", 32'(bus.s_req_ready_o), 32'd1);
        $display("txn reset_mid tag=1 dropped");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
